// File: rtl/ctrl_pkg.sv
// Shared encodings for the I2S receive path: serial standards, FSM states, word sizing.
// The optional error counter is enabled by defining RX_ERR_CNT_EN (see i2s_rx_deserializer).
package ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        STD_I2S    = 2'b00,
        STD_LEFT_J = 2'b01
    } std_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_SHIFT = 2'b10
    } state_e;

    // Index of the last bit of a word, i.e. the bit counter load value.
    function automatic logic [4:0] last_bit_idx(input logic frame_size);
        return frame_size ? 5'd31 : 5'd15;
    endfunction

    // Reserved encodings fall back to I2S timing.
    function automatic logic is_left_j(input logic [1:0] standard);
        return standard == STD_LEFT_J;
    endfunction

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Parallel word output bus of the I2S receiver.
interface i2s_rx_deserializer_if;
    import ctrl_pkg::*;

    // A word moves on the rising clock edge where rx_valid && rx_ready; while rx_valid is
    // high and rx_ready is low, the master holds rx_data/rx_ch stable.
    logic [WORD_W-1:0] rx_data;
    logic              rx_ch;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_ch,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_ch,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/rx_word_buf.sv
// Two-entry word FIFO; a push into a full buffer is accepted only when a pop frees a slot.
module rx_word_buf
    import ctrl_pkg::*;
(
    input  logic              rclk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              push_ch,
    input  logic              pop,
    output logic              valid,
    output logic              full,
    output logic [WORD_W-1:0] head_data,
    output logic              head_ch,
    output logic              dropped
);

    logic [WORD_W-1:0] data_mem [2];
    logic              ch_mem   [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign valid     = (count != 2'd0);
    assign full      = (count == 2'd2);
    assign do_pop    = pop && valid;
    assign do_push   = push && (!full || do_pop);
    assign dropped   = push && !do_push;
    assign head_data = data_mem[rd_ptr];
    assign head_ch   = ch_mem[rd_ptr];

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            data_mem[0] <= '0;
            data_mem[1] <= '0;
            ch_mem[0]   <= 1'b0;
            ch_mem[1]   <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                ch_mem[wr_ptr]   <= push_ch;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S / left-justified serial receiver delivering right-aligned words through a 2-entry buffer.
// Define RX_ERR_CNT_EN to add the saturating err_cnt output (ovf + sync_err events).
module i2s_rx_deserializer
    import ctrl_pkg::*;
(
    input  logic                   rclk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   stereo,
    input  logic                   frame_size,
    input  logic [1:0]             standard,
    input  logic                   sd,
    input  logic                   ws,
    i2s_rx_deserializer_if.master  rx,
    output logic                   ovf,
    output logic                   sync_err,
    output state_e                 state_dbg
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    state_e            state;
    state_e            state_nxt;
    logic              start_word;
    logic              ws_q;
    logic              ws_edge;
    logic              busy;
    logic              cap_ch;
    logic [4:0]        bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_data;
    logic              capturing;
    logic              word_done;
    logic              trunc;
    logic              push;
    logic              dropped;
    logic              buf_full;

    assign ws_edge   = (ws != ws_q);
    assign state_dbg = state;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every ws edge seen while enabled and out of IDLE opens a new word for the new channel.
    always_comb begin
        state_nxt  = state;
        start_word = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (ws_edge) begin
                    state_nxt  = ST_SHIFT;
                    start_word = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (ws_edge) begin
                    start_word = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign capturing = (state == ST_SHIFT) && en && busy && !ws_edge;
    assign word_done = capturing && (bit_cnt == 5'd0);
    assign trunc     = (state == ST_SHIFT) && en && ws_edge && busy;
    assign word_data = {shreg[WORD_W-2:0], sd};
    assign push      = word_done && (stereo || !cap_ch);

    // Size and standard are sampled only when a word opens, so mid-word changes are ignored.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q    <= 1'b0;
            busy    <= 1'b0;
            cap_ch  <= 1'b0;
            bit_cnt <= 5'd0;
            shreg   <= '0;
        end else begin
            ws_q <= ws;
            if (start_word) begin
                cap_ch <= ws;
                busy   <= 1'b1;
                if (is_left_j(standard)) begin
                    shreg   <= {{(WORD_W-1){1'b0}}, sd};
                    bit_cnt <= last_bit_idx(frame_size) - 5'd1;
                end else begin
                    shreg   <= '0;
                    bit_cnt <= last_bit_idx(frame_size);
                end
            end else if (capturing) begin
                shreg <= word_data;
                if (bit_cnt == 5'd0) begin
                    busy <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end else if ((state != ST_SHIFT) || !en) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ovf      <= dropped;
            sync_err <= trunc;
        end
    end

    rx_word_buf u_buf (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word_data),
        .push_ch   (cap_ch),
        .pop       (rx.rx_ready),
        .valid     (rx.rx_valid),
        .full      (buf_full),
        .head_data (rx.rx_data),
        .head_ch   (rx.rx_ch),
        .dropped   (dropped)
    );

`ifdef RX_ERR_CNT_EN
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + {8'd0, ovf} + {8'd0, sync_err};

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: slot-level serial driver, word scoreboard, pulse counters.
// Define RX_ERR_CNT_EN for both RTL and bench to also check err_cnt.
module tb_i2s_rx_deserializer;
  import ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic stereo = 1'b1;
  logic frame_size = 1'b0;
  logic [1:0] standard = 2'b00;
  logic sd = 1'b0;
  logic ws = 1'b0;
  logic ovf;
  logic sync_err;
  state_e state_dbg;
`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  i2s_rx_deserializer_if bus();

  always #5 rclk = ~rclk;

  i2s_rx_deserializer dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .en         (en),
    .stereo     (stereo),
    .frame_size (frame_size),
    .standard   (standard),
    .sd         (sd),
    .ws         (ws),
    .rx         (bus),
    .ovf        (ovf),
    .sync_err   (sync_err),
    .state_dbg  (state_dbg)
`ifdef RX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // ---------------- model state / scoreboard ----------------
  logic [32:0] exp_q[$];       // {channel, right-aligned word}
  int n_vec = 0;
  int n_err = 0;
  int ovf_seen = 0;
  int serr_seen = 0;
  int exp_ovf = 0;
  int exp_serr = 0;
  int exp_err_cnt = 0;
  int ready_mode = 1;          // 0 random, 1 always ready, 2 never ready
  int occ = 0;                 // words held while the consumer is stalled
  bit pending_partial = 1'b0;  // a capture is open and will be cut by the next ws edge
  logic ws_cur = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge rclk) begin
    logic [32:0] e;
    case (ready_mode)
      0:       bus.rx_ready = ($urandom_range(0, 3) != 0);
      1:       bus.rx_ready = 1'b1;
      default: bus.rx_ready = 1'b0;
    endcase
    if (rst_n) begin
      if (ovf) ovf_seen++;
      if (sync_err) serr_seen++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got ch=%0d data=%h, expected no word", bus.rx_ch, bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", {31'b0, bus.rx_ch, bus.rx_data}, {31'b0, e});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One ws slot: ws flips to the opposite channel, the word is placed MSB first per standard,
  // remaining slot cycles carry random bits. Standard/size pins are scrambled mid-slot.
  task automatic send_slot(input logic [1:0] std, input logic fs32, input logic [31:0] data,
                           input int slot_len, input int drop_at, input bit chk_lat);
    logic ch = ~ws_cur;
    int nb = fs32 ? 32 : 16;
    bit lj = (std == 2'b01);
    int need = nb + (lj ? 0 : 1);
    bit complete = (slot_len >= need) && (drop_at < 0);
    logic [31:0] wd = fs32 ? data : {16'h0000, data[15:0]};
    int bp;
    if (pending_partial) begin
      exp_serr++;
      exp_err_cnt = sat_inc(exp_err_cnt);
    end
    if (complete && (stereo || ch == 1'b0)) begin
      if (ready_mode == 2 && occ == 2) begin
        exp_ovf++;
        exp_err_cnt = sat_inc(exp_err_cnt);
      end else begin
        exp_q.push_back({ch, wd});
        if (ready_mode == 2) occ++;
      end
    end
    pending_partial = !complete && (drop_at < 0);
    ws_cur = ch;
    ws = ch;
    standard = std;
    frame_size = fs32;
    for (int k = 0; k < slot_len; k++) begin
      bp = lj ? k : k - 1;
      sd = (bp >= 0 && bp < nb) ? data[nb-1-bp] : 1'($urandom);
      if (k == 3) begin
        standard = 2'($urandom);
        frame_size = 1'($urandom);
      end
      en = (drop_at >= 0 && k >= drop_at && k < drop_at + 3) ? 1'b0 : 1'b1;
      @(negedge rclk);
      if (chk_lat && k == need - 2) check("lat_before_last", 64'(bus.rx_valid), 64'd0);
      if (chk_lat && k == need - 1) begin
        check("lat_valid", 64'(bus.rx_valid), 64'd1);
        check("lat_data", 64'(bus.rx_data), 64'(wd));
      end
    end
  endtask

  task automatic checkpoint(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge rclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain: %0d words outstanding after 400 cycles, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge rclk);
    check({tag, "_ovf_count"}, 64'(ovf_seen), 64'(exp_ovf));
    check({tag, "_sync_err_count"}, 64'(serr_seen), 64'(exp_serr));
`ifdef RX_ERR_CNT_EN
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err_cnt));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] std;
    logic fs32;
    int nb;
    int need;
    int len;

    bus.rx_ready = 1'b1;
    repeat (3) @(negedge rclk);
    check("rst_valid", 64'(bus.rx_valid), 64'd0);
    check("rst_data", 64'(bus.rx_data), 64'd0);
    check("rst_ch", 64'(bus.rx_ch), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge rclk);

    // I2S 16-bit stereo: leading right slot supplies the first ws edge
    send_slot(2'b00, 1'b0, 32'h0000_0F0F, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_A5C3, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_1234, 20, -1, 1'b0);
    checkpoint("i2s16");

    // Left-justified 32-bit with exact output latency
    send_slot(2'b01, 1'b1, 32'hDEAD_BEEF, 36, -1, 1'b1);
    send_slot(2'b01, 1'b1, 32'h0123_4567, 34, -1, 1'b0);
    checkpoint("lj32");

    // Consumer stalled: three words, two held, one dropped
    ready_mode = 2;
    occ = 0;
    @(negedge rclk);
    send_slot(2'b00, 1'b0, 32'h0000_1111, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_2222, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_3333, 20, -1, 1'b0);
    repeat (2) @(negedge rclk);
    check("ovf_head_valid", 64'(bus.rx_valid), 64'd1);
    check("ovf_head_data", 64'(bus.rx_data), 64'h1111);
    ready_mode = 1;
    occ = 0;
    checkpoint("ovf");

    // ws edge after 10 bits of a 16-bit I2S word
    send_slot(2'b00, 1'b0, 32'h0000_BAD0, 11, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_5A5A, 18, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_C3C3, 18, -1, 1'b0);
    checkpoint("sync");

    // Mono: right words vanish without overflow
    stereo = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_slot(2'($urandom_range(0, 1)), 1'b0, $urandom, 20, -1, 1'b0);
    end
    checkpoint("mono");
    stereo = 1'b1;

    // en drop mid-word: partial lost, buffered word kept
    ready_mode = 2;
    occ = 0;
    @(negedge rclk);
    send_slot(2'b00, 1'b0, 32'h0000_7E57, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_DEAD, 25, 5, 1'b0);
    ready_mode = 1;
    occ = 0;
    send_slot(2'b01, 1'b0, 32'h0000_BEEF, 20, -1, 1'b0);
    send_slot(2'b00, 1'b1, 32'hCAFE_F00D, 36, -1, 1'b0);
    checkpoint("en_drop");

    // Randomized slots with random backpressure, config and occasional truncation
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      std = 2'($urandom_range(0, 3));
      fs32 = 1'($urandom);
      nb = fs32 ? 32 : 16;
      need = nb + ((std == 2'b01) ? 0 : 1);
      stereo = 1'($urandom);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(2, need - 1);
      else len = need + $urandom_range(0, 5);
      send_slot(std, fs32, $urandom, len, -1, 1'b0);
    end
    send_slot(2'b00, 1'b0, $urandom, 20, -1, 1'b0);
    ready_mode = 1;
    stereo = 1'b1;
    checkpoint("rand");

    // Reset mid-word with a full buffer
    ready_mode = 2;
    occ = 0;
    @(negedge rclk);
    send_slot(2'b00, 1'b0, 32'h0000_AAAA, 20, -1, 1'b0);
    send_slot(2'b00, 1'b0, 32'h0000_5555, 20, -1, 1'b0);
    ws_cur = ~ws_cur;
    ws = ws_cur;
    standard = 2'b00;
    frame_size = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sd = 1'($urandom);
      @(negedge rclk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.rx_valid), 64'd0);
    check("midrst_data", 64'(bus.rx_data), 64'd0);
    check("midrst_ch", 64'(bus.rx_ch), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_sync_err", 64'(sync_err), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
`ifdef RX_ERR_CNT_EN
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    exp_q.delete();
    occ = 0;
    pending_partial = 1'b0;
    exp_err_cnt = 0;
    ready_mode = 1;
    @(negedge rclk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      sd = 1'($urandom);
      @(negedge rclk);
    end
    check("post_rst_no_word", 64'(bus.rx_valid), 64'd0);
    send_slot(2'b00, 1'b0, 32'h0000_9876, 20, -1, 1'b0);
    send_slot(2'b01, 1'b1, 32'h8765_4321, 34, -1, 1'b0);
    checkpoint("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
